rf_wb_ctrl: RTL

Write-back controller for the 32x32 register file, which has one write port and two asynchronous read ports.
- Two producers compete for the single write port: the ALU and the load/store unit (LSU).
- Arbitrates them round-robin and drives a registered write port into the register file.
- Keeps a busy scoreboard of registers with outstanding writes and flags read-after-write and write-after-write hazards to the issue stage.

---
 rtl/rf_pkg.sv | 16 +
 rtl/rr_arb2.sv | 40 ++++
 rtl/rf_wb_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared constants and payload types for the register-file write-back controller.
package rf_pkg;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LSU = 1'b1
  } grant_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 is the ALU, bit 1 the LSU.
module rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  grant_t last_q;
  grant_t last_d;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_q == GNT_ALU) ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt[0]) begin
      last_d = GNT_ALU;
    end else if (gnt[1]) begin
      last_d = GNT_LSU;
    end
  end

  // Starting as if the LSU won last hands the first tie to the ALU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= GNT_LSU;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Write-back controller: arbitrates ALU/LSU onto one registered RF write port
// and tracks outstanding destination registers for hazard detection.
module rf_wb_ctrl
  import rf_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                alu_valid_i,
  output logic                alu_ready_o,
  input  logic [ADDR_W-1:0]   alu_addr_i,
  input  logic [XLEN-1:0]     alu_data_i,
  input  logic                lsu_valid_i,
  output logic                lsu_ready_o,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic [XLEN-1:0]     lsu_data_i,
  input  logic                issue_valid_i,
  input  logic [ADDR_W-1:0]   issue_rd_i,
  input  logic [ADDR_W-1:0]   rs1_addr_i,
  input  logic [ADDR_W-1:0]   rs2_addr_i,
  output logic                hazard_o,
  output logic                rf_we_o,
  output logic [ADDR_W-1:0]   rf_waddr_o,
  output logic [XLEN-1:0]     rf_wdata_o,
  output logic [NUM_REGS-1:0] busy_o
);

  logic [1:0]          gnt;
  wb_req_t             alu_req;
  wb_req_t             lsu_req;
  wb_req_t             sel_req;

  logic                rf_we_q;
  logic                rf_we_d;
  logic [ADDR_W-1:0]   rf_waddr_q;
  logic [ADDR_W-1:0]   rf_waddr_d;
  logic [XLEN-1:0]     rf_wdata_q;
  logic [XLEN-1:0]     rf_wdata_d;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  rr_arb2 u_arb (
    .clk (clk_i),
    .rst (rst_i),
    .req ({lsu_valid_i, alu_valid_i}),
    .gnt (gnt)
  );

  assign alu_ready_o = gnt[0];
  assign lsu_ready_o = gnt[1];

  assign alu_req = '{addr: alu_addr_i, data: alu_data_i};
  assign lsu_req = '{addr: lsu_addr_i, data: lsu_data_i};
  assign sel_req = gnt[1] ? lsu_req : alu_req;

  // x0 grants are accepted but never reach the register file.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if ((gnt != 2'b00) && (sel_req.addr != '0)) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = sel_req.addr;
      rf_wdata_d = sel_req.data;
    end
  end

  // Clear on actual write, then set on issue so a new producer wins the tie.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q) begin
      busy_d[rf_waddr_q] = 1'b0;
    end
    if (issue_valid_i && (issue_rd_i != '0)) begin
      busy_d[issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign hazard_o = ((rs1_addr_i != '0) && busy_q[rs1_addr_i])
                  | ((rs2_addr_i != '0) && busy_q[rs2_addr_i])
                  | (issue_valid_i && (issue_rd_i != '0) && busy_q[issue_rd_i]);

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign busy_o     = busy_q;

endmodule
